// File: rtl/data_mem_requester_pkg.sv
// Shared data-memory interface definitions: FSM state encodings, default
// memory depth and the read/write encoding used on the memory bus.
package data_mem_requester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_DEFAULT   = 16;
    localparam int TIMEOUT_DEFAULT = 8;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/data_mem_requester_if.sv
// Single-ported data-memory valid/rw/ready bus.
// master = requester (drives the request), slave = data memory (drives ready/data).
interface data_mem_requester_if;

    logic        mem_valid;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_ready;
    logic [31:0] mem_rd_data;

    modport master (
        output mem_valid, mem_rw, mem_addr, mem_wr_data,
        input  mem_ready, mem_rd_data
    );

    modport slave (
        input  mem_valid, mem_rw, mem_addr, mem_wr_data,
        output mem_ready, mem_rd_data
    );

endinterface

// File: rtl/data_mem_requester.sv
// Memory-stage requester: takes one load/store from the pipeline, issues it on
// the data-memory bus, stalls the pipeline until ready (or timeout / range
// error), then reports completion with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for cpu_req; range check happens here
//   BUSY  | request on the bus, waiting for mem_ready or timeout
//   RESP  | one-cycle cpu_done / cpu_err report, then back to IDLE
module data_mem_requester
    import data_mem_requester_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT  // must be >= 2: nominal ready takes one cycle
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_req,
    input  logic                        cpu_rw,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wr_data,
    output logic                        cpu_stall,
    output logic                        cpu_done,
    output logic                        cpu_err,
    output logic [31:0]                 cpu_rd_data,
    data_mem_requester_if.master        mem
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]     DEPTH_U  = 32'(DEPTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_flag, err_nxt;
    logic             valid_q, valid_nxt;
    logic             rw_q, rw_nxt;
    logic [31:0]      addr_q, addr_nxt;
    logic [31:0]      wd_q, wd_nxt;
    logic [31:0]      rd_q, rd_nxt;

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            err_flag <= 1'b0;
            valid_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            rd_q     <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            err_flag <= err_nxt;
            valid_q  <= valid_nxt;
            rw_q     <= rw_nxt;
            addr_q   <= addr_nxt;
            wd_q     <= wd_nxt;
            rd_q     <= rd_nxt;
        end
    end

    // Next-state, request latching, ready/timeout handling and load capture.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_flag;
        valid_nxt = valid_q;
        rw_nxt    = rw_q;
        addr_nxt  = addr_q;
        wd_nxt    = wd_q;
        rd_nxt    = rd_q;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_addr < DEPTH_U) begin
                        rw_nxt    = cpu_rw;
                        addr_nxt  = cpu_addr;
                        wd_nxt    = cpu_wr_data;
                        valid_nxt = 1'b1;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                        state_nxt = BUSY;
                    end else begin
                        // Out of range: never touches the bus.
                        err_nxt   = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            BUSY: begin
                if (mem.mem_ready) begin
                    valid_nxt = 1'b0;
                    if (rw_q == MEM_RD) begin
                        rd_nxt = mem.mem_rd_data;
                    end
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pipeline-side outputs; stall drops in RESP so the pipeline advances with done.
    always_comb begin
        cpu_stall   = (state == BUSY) || ((state == IDLE) && cpu_req);
        cpu_done    = (state == RESP);
        cpu_err     = (state == RESP) && err_flag;
        cpu_rd_data = rd_q;
    end

    assign mem.mem_valid   = valid_q;
    assign mem.mem_rw      = rw_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wr_data = wd_q;

endmodule

// File: doc/data_mem_requester.md
Name: data_mem_requester

Overview:
- Initiator side of the single-ported data-memory valid/rw/ready protocol. It sits in the processor memory stage between the pipeline and the data memory.
- Accepts one load or store from the pipeline, drives the memory request, and waits for ready. It stalls the pipeline while the access is outstanding, then returns load data, a done pulse and an error flag.
- Adds an address range check and a ready timeout so a missing responder cannot hang the core.

Parameters:
DEPTH, 16, number of 32-bit words in data memory; word-indexed addresses 0..DEPTH-1 are legal
TIMEOUT, 8, maximum cycles mem_valid stays high waiting for mem_ready before the access is aborted

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  pipeline requests an access; held stable while cpu_stall=1
cpu_rw  in  1  1=store, 0=load
cpu_addr  in  32  word address
cpu_wr_data  in  32  store data
cpu_stall  out  1  combinational; freeze pipeline
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  valid with cpu_done; 1=out-of-range or timeout
cpu_rd_data  out  32  last successful load data; held until the next successful load
mem_valid  out  1  registered request valid to memory
mem_rw  out  1  registered; 1=write
mem_addr  out  32  registered address
mem_wr_data  out  32  registered write data
mem_ready  in  1  memory completion strobe; registered in memory, one cycle wide
mem_rd_data  in  32  read data; valid in the cycle mem_ready=1 for a read

Behaviour:
- Reset: state=IDLE; mem_valid, mem_rw, cpu_done, cpu_err = 0; mem_addr, mem_wr_data, cpu_rd_data = 0; timeout counter = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE, cpu_req=1, cpu_addr<DEPTH: latch rw/addr/wr_data into the mem_* registers; mem_valid<=1; counter<=0; go to BUSY.
- IDLE, cpu_req=1, cpu_addr>=DEPTH: no memory access, mem_valid stays 0; set err flag; go to RESP.
- BUSY, mem_ready=1: mem_valid<=0. If mem_rw=0, cpu_rd_data<=mem_rd_data. Err flag=0; go to RESP.
- BUSY, mem_ready=0, counter==TIMEOUT-1: mem_valid<=0; err flag=1; go to RESP. cpu_rd_data is unchanged.
- BUSY, otherwise: counter increments.
- RESP: cpu_done=1 and cpu_err=err flag for exactly this one cycle; unconditionally go to IDLE. cpu_req is ignored in RESP.
- cpu_stall = (state==BUSY) | (state==IDLE & cpu_req). It is 0 in RESP, so the pipeline advances in the done cycle.
- Nominal latency, counted from the edge that accepts the request (E0):
  - mem_valid is high from E0.
  - Memory samples at E1; mem_ready is high after E1.
  - The requester sees ready at E2; mem_valid drops at E2; cpu_done is high in the cycle after E2.
  - mem_valid is high for exactly 2 cycles per access. Dropping at E2 is legal because memory ignores valid while its ready is high.
- mem_ready seen in IDLE or RESP (late, stale or spurious) is ignored: no state change, no data capture.
- Back-to-back requests: the minimum spacing is one IDLE cycle between a RESP cycle and the next accept.
- Reset during BUSY: returns to IDLE with mem_valid=0 on the next edge. A trailing mem_ready from the aborted access lands in IDLE and is ignored. No cpu_done is produced for the aborted access.
- Counter width is clog2(TIMEOUT+1). TIMEOUT>=2 is required because the nominal ready arrives after 1 cycle.
- Address comparison is unsigned, full 32 bits.

Decomposition:
- Shared header (data-memory interface include): FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), DEPTH default, rw encoding constants (MEM_RD=0, MEM_WR=1). The data memory and this requester both use these.
- No sub-module. The timeout counter is a few lines inside the FSM.

Test Plan:
- Load addr 1 against the data-memory model -> mem_valid high 2 cycles; cpu_done 3 cycles after accept; cpu_rd_data=32'h1; cpu_err=0.
- Store 32'hDEADBEEF to addr 5, then load addr 5 -> both done with err=0; cpu_rd_data=32'hDEADBEEF; cpu_stall high for 3 cycles per access.
- Load addr 20 (DEPTH=16) -> mem_valid never asserts; cpu_done+cpu_err 1 cycle after accept; cpu_rd_data unchanged.
- Responder tied mem_ready=0 -> mem_valid high exactly 8 cycles, then cpu_done+cpu_err=1; the following normal load completes correctly.
- rst pulsed one cycle after accept -> mem_valid=0 next edge; trailing mem_ready ignored; no cpu_done; next load addr 1 returns 32'h1.
- Four back-to-back stores to addrs 2,3,4,5 with cpu_req held high -> each accepted in IDLE after RESP; 4 done pulses; memory contents match.
